// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Issue side of the ALU interface. Instructions are accepted over a
// valid/ready handshake, decoded into the ALU control code, and their operands
// are read from an internal 32 x 32 register file. The unit drives the external
// combinational ALU and writes its result back.
// Sequence: IDLE -> DECODE -> EXEC (ALU_LATENCY cycles) -> WB -> IDLE.
//
// Parameters:
//   ALU_LATENCY  cycles EXEC waits for alu_result to settle (1..15)
//   REG_RESET    reset value of every architectural register
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   instr         32-bit R-type instruction
//   instr_valid   instr is valid
//   instr_ready   unit can accept an instruction (IDLE only)
//   alu_a/alu_b   ALU operands
//   alu_control   4-bit ALU op code
//   alu_result    combinational ALU result
//   done          1-cycle pulse, instruction retired (legal or not)
//   illegal_op    1-cycle pulse with done, unknown opcode/funct
//   div_zero      1-cycle pulse with done, DIV by a zero register
//   dbg_addr      debug register read address
//   dbg_data      combinational read of regs[dbg_addr] (r0 reads 0)
//
// Optional feature (macro ISSUE_PERF_CNT_EN):
//   adds retire_cnt[31:0] and illegal_cnt[15:0]. Both counters reset to 0,
//   count retired and illegal instructions respectively, and wrap at max.
// ---------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [31:0] REG_RESET   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        illegal_op,
  output logic        div_zero,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [15:0] illegal_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;
  localparam logic [5:0] F_DIV = 6'h1A;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] aluA_q, aluB_q;
  logic [3:0]  aluCtrl_q;
  logic [3:0]  cnt_q;
  logic [31:0] wbData_q;
  logic        legal_q;
  logic        divZeroPend_q;
  logic        done_q, illegalOp_q, divZeroOut_q;
  logic [31:0] regs_q [32];

  logic [5:0]  opField, functField;
  logic [4:0]  rsField, rtField, rdField, shamtField;
  logic [31:0] rsVal, rtVal;
  logic [31:0] decA, decB;
  logic [3:0]  decCtrl;
  logic        decLegal, decShift, decDivZero;

  assign opField    = instr_q[31:26];
  assign rsField    = instr_q[25:21];
  assign rtField    = instr_q[20:16];
  assign rdField    = instr_q[15:11];
  assign shamtField = instr_q[10:6];
  assign functField = instr_q[5:0];

  // r0 is architecturally zero whatever its storage holds
  assign rsVal    = (rsField == 5'd0) ? 32'd0 : regs_q[rsField];
  assign rtVal    = (rtField == 5'd0) ? 32'd0 : regs_q[rtField];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

  assign instr_ready = (state_q == S_IDLE);
  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_control = aluCtrl_q;
  assign done        = done_q;
  assign illegal_op  = illegalOp_q;
  assign div_zero    = divZeroOut_q;

  // Decode the captured instruction. Shifts take the value from rt and the
  // shift amount from shamt; illegal instructions present all-zero operands.
  always_comb begin
    decCtrl  = 4'b0000;
    decLegal = 1'b1;
    decShift = 1'b0;
    if (opField != 6'd0) begin
      decLegal = 1'b0;
    end else begin
      unique case (functField)
        F_ADD:   decCtrl = 4'b0000;
        F_SUB:   decCtrl = 4'b0001;
        F_AND:   decCtrl = 4'b0010;
        F_OR:    decCtrl = 4'b0011;
        F_SLL:   begin decCtrl = 4'b0100; decShift = 1'b1; end
        F_SRL:   begin decCtrl = 4'b0101; decShift = 1'b1; end
        F_SLT:   decCtrl = 4'b0110;
        F_MUL:   decCtrl = 4'b0111;
        F_DIV:   decCtrl = 4'b1000;
        default: decLegal = 1'b0;
      endcase
    end
    decA       = decShift ? rtVal : rsVal;
    decB       = decShift ? {27'd0, shamtField} : rtVal;
    decDivZero = decLegal && (functField == F_DIV) && (rtVal == 32'd0);
    if (!decLegal) begin
      decA = 32'd0;
      decB = 32'd0;
    end
  end

  // Next-state logic; illegal instructions bypass EXEC entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = decLegal ? S_EXEC : S_WB;
      S_EXEC:   if (cnt_q == 4'd0) state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers. done and its companion flags are set on
  // the WB edge, so they become visible together with the register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= 32'd0;
      aluA_q        <= 32'd0;
      aluB_q        <= 32'd0;
      aluCtrl_q     <= 4'b0000;
      cnt_q         <= 4'd0;
      wbData_q      <= 32'd0;
      legal_q       <= 1'b0;
      divZeroPend_q <= 1'b0;
      done_q        <= 1'b0;
      illegalOp_q   <= 1'b0;
      divZeroOut_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= 1'b0;
      illegalOp_q  <= 1'b0;
      divZeroOut_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) instr_q <= instr;
        end
        S_DECODE: begin
          aluA_q        <= decA;
          aluB_q        <= decB;
          aluCtrl_q     <= decCtrl;
          legal_q       <= decLegal;
          divZeroPend_q <= decDivZero;
          cnt_q         <= LAT_M1;
        end
        S_EXEC: begin
          // A zero divisor overrides whatever the ALU produces
          if (cnt_q == 4'd0) begin
            wbData_q <= divZeroPend_q ? 32'hFFFF_FFFF : alu_result;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WB: begin
          done_q       <= 1'b1;
          illegalOp_q  <= ~legal_q;
          divZeroOut_q <= divZeroPend_q;
        end
        default: ;
      endcase
    end
  end

  // Architectural register file; writes to r0 and from illegal ops are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= REG_RESET;
    end else if ((state_q == S_WB) && legal_q && (rdField != 5'd0)) begin
      regs_q[rdField] <= wbData_q;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] retireCnt_q;
  logic [15:0] illegalCnt_q;

  // Counters advance on the same edge that raises done / illegal_op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retireCnt_q  <= 32'd0;
      illegalCnt_q <= 16'd0;
    end else if (state_q == S_WB) begin
      retireCnt_q <= retireCnt_q + 32'd1;
      if (!legal_q) illegalCnt_q <= illegalCnt_q + 16'd1;
    end
  end

  assign retire_cnt  = retireCnt_q;
  assign illegal_cnt = illegalCnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

   localparam int LAT = 2;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] expA;
      logic [31:0] expB;
      logic [3:0]  expCtrl;
      logic [4:0]  chkAddr;
      logic [31:0] chkVal;
      bit          ill;
      bit          dz;
   } vec_t;

   typedef struct {
      int acceptNeg;
      int expLat;
      bit ill;
      bit dz;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_control;
   logic [31:0] aluResult;
   logic        done, illegal_op, div_zero;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data;
`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] retire_cnt;
   logic [15:0] illegal_cnt;
`endif

   int   checks = 0;
   int   fails = 0;
   int   negCount = 0;
   int   doneCount = 0;
   int   issued = 0;
   sb_t  sbQ[$];
   vec_t tbl[20];

   always #5 clk = ~clk;

   alu_issue_unit #(.ALU_LATENCY(LAT), .REG_RESET(32'd0)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .alu_result(aluResult), .done(done),
      .illegal_op(illegal_op), .div_zero(div_zero), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
`ifdef ISSUE_PERF_CNT_EN
      , .retire_cnt(retire_cnt), .illegal_cnt(illegal_cnt)
`endif
   );

   // Reference combinational ALU sitting on the far side of the interface
   always_comb begin
      case (alu_control)
         4'd0:    aluResult = alu_a + alu_b;
         4'd1:    aluResult = alu_a - alu_b;
         4'd2:    aluResult = alu_a & alu_b;
         4'd3:    aluResult = alu_a | alu_b;
         4'd4:    aluResult = alu_a << alu_b[4:0];
         4'd5:    aluResult = alu_a >> alu_b[4:0];
         4'd6:    aluResult = (alu_a < alu_b) ? 32'd1 : 32'd0;
         4'd7:    aluResult = alu_a * alu_b;
         4'd8:    aluResult = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
         default: aluResult = 32'd0;
      endcase
   end

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
      return {op, rs, rt, rd, sh, fn};
   endfunction

   function automatic vec_t mkVec(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] c,
                                  input logic [4:0] addr, input logic [31:0] val,
                                  input bit ill, input bit dz);
      vec_t v;
      v.instr = ins; v.expA = a; v.expB = b; v.expCtrl = c;
      v.chkAddr = addr; v.chkVal = val; v.ill = ill; v.dz = dz;
      return v;
   endfunction

   // One comparison: counts it, reports a FAIL line on disagreement
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard side: every done must match the oldest outstanding issue
   always @(negedge clk) begin
      negCount <= negCount + 1;
      if (rst_n && done) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'd0);
         end else begin
            checkOutput("done_latency", 32'(negCount + 1 - sbQ[0].acceptNeg), 32'(sbQ[0].expLat));
            checkOutput("illegal_op", 32'(illegal_op), 32'(sbQ[0].ill));
            checkOutput("div_zero", 32'(div_zero), 32'(sbQ[0].dz));
            void'(sbQ.pop_front());
            doneCount <= doneCount + 1;
         end
      end else if (rst_n && (illegal_op || div_zero)) begin
         checkOutput("flag_without_done", 32'({illegal_op, div_zero}), 32'd0);
      end
   end

   task automatic checkReg(input string name, input logic [4:0] addr, input logic [31:0] exp);
      dbg_addr = addr;
      #1;
      checkOutput(name, dbg_data, exp);
   endtask

   task automatic waitDone();
      for (int i = 0; i < 60 && doneCount < issued; i++) @(negedge clk);
      if (doneCount < issued) begin
         checks++;
         fails++;
         $display("[TB] FAIL done_timeout: got %0d retires expected %0d", doneCount, issued);
      end
   endtask

   // Issue one instruction, check the operands EXEC presents, wait for retire
   // and read back the destination register
   task automatic applyStimulus(input vec_t v, input string name);
      sb_t e;
      int  waitCnt;
      waitCnt = 0;
      @(negedge clk);
      while (!instr_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!instr_ready) begin
         checkOutput({name, "_ready_timeout"}, 32'(instr_ready), 32'd1);
         return;
      end
      instr = v.instr;
      instr_valid = 1'b1;
      @(posedge clk);
      e.acceptNeg = negCount + 1;
      e.expLat = v.ill ? 2 : 2 + LAT;
      e.ill = v.ill;
      e.dz = v.dz;
      sbQ.push_back(e);
      issued++;
      // valid while busy must be ignored; a stray accept shows up as an extra done
      #1 instr = enc(6'd0, 5'd1, 5'd1, 5'd31, 5'd0, 6'h20);
      @(negedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      checkOutput({name, "_alu_a"}, alu_a, v.expA);
      checkOutput({name, "_alu_b"}, alu_b, v.expB);
      checkOutput({name, "_alu_control"}, 32'(alu_control), 32'(v.expCtrl));
      waitDone();
      checkReg({name, "_reg"}, v.chkAddr, v.chkVal);
   endtask

   initial begin
      // Build r1=7 and r2=5 from an all-zero file, then exercise every op
      tbl[0]  = mkVec(enc(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h1A), 32'd0, 32'd0, 4'h8, 5'd1, 32'hFFFF_FFFF, 0, 1);
      tbl[1]  = mkVec(enc(6'd0, 5'd0, 5'd1, 5'd2, 5'd0, 6'h22), 32'd0, 32'hFFFF_FFFF, 4'h1, 5'd2, 32'd1, 0, 0);
      tbl[2]  = mkVec(enc(6'd0, 5'd0, 5'd2, 5'd3, 5'd3, 6'h00), 32'd1, 32'd3, 4'h4, 5'd3, 32'd8, 0, 0);
      tbl[3]  = mkVec(enc(6'd0, 5'd3, 5'd2, 5'd1, 5'd0, 6'h22), 32'd8, 32'd1, 4'h1, 5'd1, 32'd7, 0, 0);
      tbl[4]  = mkVec(enc(6'd0, 5'd0, 5'd2, 5'd3, 5'd2, 6'h00), 32'd1, 32'd2, 4'h4, 5'd3, 32'd4, 0, 0);
      tbl[5]  = mkVec(enc(6'd0, 5'd3, 5'd2, 5'd2, 5'd0, 6'h20), 32'd4, 32'd1, 4'h0, 5'd2, 32'd5, 0, 0);
      tbl[6]  = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd7, 32'd5, 4'h0, 5'd3, 32'd12, 0, 0);
      tbl[7]  = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'd7, 32'd5, 4'h1, 5'd4, 32'd2, 0, 0);
      tbl[8]  = mkVec(enc(6'd0, 5'd0, 5'd1, 5'd5, 5'd4, 6'h00), 32'd7, 32'd4, 4'h4, 5'd5, 32'd112, 0, 0);
      tbl[9]  = mkVec(enc(6'd0, 5'd1, 5'd0, 5'd6, 5'd0, 6'h1A), 32'd7, 32'd0, 4'h8, 5'd6, 32'hFFFF_FFFF, 0, 1);
      tbl[10] = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h1A), 32'd7, 32'd5, 4'h8, 5'd7, 32'd1, 0, 0);
      tbl[11] = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h24), 32'd7, 32'd5, 4'h2, 5'd8, 32'd5, 0, 0);
      tbl[12] = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h25), 32'd7, 32'd5, 4'h3, 5'd9, 32'd7, 0, 0);
      tbl[13] = mkVec(enc(6'd0, 5'd0, 5'd3, 5'd10, 5'd2, 6'h02), 32'd12, 32'd2, 4'h5, 5'd10, 32'd3, 0, 0);
      tbl[14] = mkVec(enc(6'd0, 5'd2, 5'd1, 5'd11, 5'd0, 6'h2A), 32'd5, 32'd7, 4'h6, 5'd11, 32'd1, 0, 0);
      tbl[15] = mkVec(enc(6'd0, 5'd1, 5'd6, 5'd12, 5'd0, 6'h2A), 32'd7, 32'hFFFF_FFFF, 4'h6, 5'd12, 32'd1, 0, 0);
      tbl[16] = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, 6'h18), 32'd7, 32'd5, 4'h7, 5'd13, 32'd35, 0, 0);
      tbl[17] = mkVec(enc(6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd0, 32'd0, 4'h0, 5'd3, 32'd12, 1, 0);
      tbl[18] = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h3F), 32'd0, 32'd0, 4'h0, 5'd4, 32'd2, 1, 0);
      tbl[19] = mkVec(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd7, 32'd5, 4'h0, 5'd0, 32'd0, 0, 0);

      // Reset held with instr_valid high: nothing may be accepted
      instr_valid = 1'b1;
      instr = enc(6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20);
      repeat (3) @(negedge clk);
      checkOutput("rst_instr_ready", 32'(instr_ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_alu_control", 32'(alu_control), 32'd0);
      checkOutput("rst_alu_a", alu_a, 32'd0);
      checkOutput("rst_alu_b", alu_b, 32'd0);
      for (int a = 0; a < 32; a++) checkReg("rst_reg", 5'(a), 32'd0);
`ifdef ISSUE_PERF_CNT_EN
      checkOutput("rst_retire_cnt", retire_cnt, 32'd0);
`endif
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));
      checkReg("r0_after_add", 5'd0, 32'd0);
      checkReg("r3_after_illegal", 5'd3, 32'd12);
`ifdef ISSUE_PERF_CNT_EN
      checkOutput("retire_cnt_20", retire_cnt, 32'd20);
      checkOutput("illegal_cnt_2", 32'(illegal_cnt), 32'd2);
`endif

      // Reset asserted while an ADD is in EXEC: aborts with no write or done
      @(negedge clk);
      instr = enc(6'd0, 5'd1, 5'd2, 5'd14, 5'd0, 6'h20);
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sbQ.delete();
      checkOutput("midexec_rst_ready", 32'(instr_ready), 32'd1);
      checkOutput("midexec_rst_done", 32'(done), 32'd0);
      checkOutput("midexec_rst_alu_a", alu_a, 32'd0);
      checkOutput("midexec_rst_ctrl", 32'(alu_control), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issued = 0;
      doneCount = 0;
      repeat (LAT + 4) @(negedge clk);
      checkReg("midexec_r14", 5'd14, 32'd0);
      checkReg("midexec_r1", 5'd1, 32'd0);
`ifdef ISSUE_PERF_CNT_EN
      checkOutput("midexec_retire_cnt", retire_cnt, 32'd0);
`endif

      applyStimulus(tbl[0], "post0");
      applyStimulus(tbl[1], "post1");
      applyStimulus(mkVec(enc(6'd0, 5'd2, 5'd2, 5'd3, 5'd0, 6'h20), 32'd1, 32'd1, 4'h0, 5'd3, 32'd2, 0, 0), "post2");
`ifdef ISSUE_PERF_CNT_EN
      checkOutput("post_retire_cnt", retire_cnt, 32'd3);
      checkOutput("post_illegal_cnt", 32'(illegal_cnt), 32'd0);
`endif
      repeat (LAT + 4) @(negedge clk);
      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
